tl_inflight_tracker: RTL and testbench
======================================

# tl_inflight_tracker

Sequential protocol checker that sits beside the TileLink monitor on the same A/D link and observes the identical channel signals. It records every outstanding request by source ID, counts data beats, and matches each D response against its request. It reports sticky error flags, an in-flight count and an optional watchdog timeout. It is observation-only: it never drives or back-pressures the link.

## Interface
- `SOURCES`, 128 — number of source IDs; `a_source`/`d_source` width is log2(SOURCES) = 7.
- `BEAT_BYTES`, 4 — data bus width in bytes; power of two.
- `TIMEOUT`, 4096 — watchdog limit in cycles; must be ≥ 2.

Ports:
- `clock` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `a_valid`, `a_ready` in 1 — A-channel handshake; A fire = both high.
- `a_opcode` in 3 — request opcode.
- `a_size` in 4 — log2 of transfer bytes.
- `a_source` in 7 — request source ID.
- `a_address` in 30 — request address; observed only, not checked.
- `d_valid`, `d_ready` in 1 — D-channel handshake; D fire = both high.
- `d_opcode` in 3 — response opcode.
- `d_size` in 4 — log2 of response bytes.
- `d_source` in 7 — response source ID.
- `d_denied` in 1 — response denied; observed only, not checked.
- `inflight_count` out 8 — number of sources currently outstanding.
- `err_sticky` out 5 — latched error flags:
  - [0] A source reuse
  - [1] D for an unknown source
  - [2] D opcode mismatch
  - [3] D size mismatch
  - [4] watchdog timeout
- `err_pulse` out 1 — high for one cycle whenever any `err_sticky` bit goes from 0 to 1.

## Operation
- Beats per message:
  - Put (opcode 0/1) and AccessAckData (d_opcode 1) carry data. Beats = 2^(size − log2 BEAT_BYTES) when size > log2 BEAT_BYTES, else 1.
  - All other messages are 1 beat.
- A-channel beat counter: a first beat is any fire while the counter is 0. The counter reloads at the first beat and decrements on later beats; the last beat returns it to 0.
- D-channel beat counter: same scheme as the A channel.
- Per-source table entry: inflight bit, expected D opcode (2 bits), size (4 bits).
- Allocation on A first-beat fire:
  - Set inflight and store the size.
  - Expected D opcode: Put(0,1) → 0; Arith(2), Logical(3), Get(4) → 1; Intent(5) → 2.
  - If the registered inflight bit is already set, set err[0]; the entry is still overwritten.
- Check on D first-beat fire:
  - Registered inflight clear → err[1]; no opcode/size check.
  - Otherwise a d_opcode mismatch sets err[2]; a d_size mismatch sets err[3].
- Release on D last-beat fire: clear inflight for d_source. An unknown source causes no release.
- Simultaneous same-source events: an A first beat and a D last beat to the same source in one cycle is a reuse error, set as err[0]. The entry ends allocated with the new A contents, because the A write wins over the clear.
- `inflight_count` = registered popcount of the inflight bits, computed incrementally as +1 on allocation of a free entry and −1 on release. Saturation is impossible because the count is ≤ SOURCES.
- Opcodes 6 and 7 on either channel are ignored; the companion monitor flags them.

## Timing
- Reset values:
  - `inflight_count` = 0, `err_sticky` = 0, `err_pulse` = 0.
  - All inflight bits, beat counters and the watchdog counter cleared.
- Reset asserted mid-transfer: all state is dropped. Beats still arriving after reset are treated as fresh messages, so a D for a pre-reset request flags err[1].
- Latency from fire:
  - Error bits and `err_pulse` are visible on the cycle after the offending fire edge.
  - `inflight_count` updates on the cycle after the fire edge.
- Table reads use state registered before the current edge. A check sees updates from earlier cycles only.
- A handshake requires `a_valid` and `a_ready` high on the same rising edge; the D channel likewise. Valid-without-ready cycles have no effect.

## Configuration
- `TL_TRACKER_WATCHDOG_EN` defined:
  - A 13-bit counter increments each cycle while `inflight_count` ≠ 0 and no D fire occurs.
  - It clears on any D fire or when `inflight_count` = 0.
  - Reaching TIMEOUT sets err[4]; the counter then holds.
- Undefined: no counter is built and err[4] is tied to 0.

## Test plan
- Get size 2, source 5, then AccessAckData size 2, source 5 → count 0→1→0, `err_sticky` = 0.
- PutFull size 4, source 3 (4 A beats), then AccessAck size 4 → one allocation only, count peaks at 1, no errors.
- Get source 9 twice with no response between → err[0] set, `err_pulse` high for exactly one cycle, count stays 1.
- D AccessAck for source 12 with nothing outstanding → err[1]; then Get source 12 answered with AccessAck (opcode 0) → err[2] also set; `err_sticky` = 5'b00110.
- Same-cycle A first beat and D last beat on source 7 → err[0] set, count unchanged at 1.
- With `TL_TRACKER_WATCHDOG_EN`: Get source 1 with no response for TIMEOUT cycles → err[4] set on the cycle the counter reaches 4096. Assert reset at that point → all outputs return to 0 on the next cycle.

Source files
------------

// File: rtl/tl_inflight_tracker.sv
// Observation-only TileLink A/D in-flight tracker: per-source request table, beat counting,
// response matching, sticky error flags. Optional watchdog under TL_TRACKER_WATCHDOG_EN.
module tl_inflight_tracker #(
    parameter int SOURCES    = 128,
    parameter int BEAT_BYTES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a_valid,
    input  logic       a_ready,
    input  logic [2:0] a_opcode,
    input  logic [3:0] a_size,
    input  logic [6:0] a_source,
    input  logic [29:0] a_address,
    input  logic       d_valid,
    input  logic       d_ready,
    input  logic [2:0] d_opcode,
    input  logic [3:0] d_size,
    input  logic [6:0] d_source,
    input  logic       d_denied,
    output logic [7:0] inflight_count,
    output logic [4:0] err_sticky,
    output logic       err_pulse
);
    localparam int LG_BB  = $clog2(BEAT_BYTES);
    localparam int BEAT_W = 15 - LG_BB;

    // Remaining beats after the first, i.e. beats-1; zero for single-beat messages.
    function automatic logic [BEAT_W-1:0] beats_m1(input logic [3:0] size, input logic data);
        logic [BEAT_W-1:0] r;
        r = '0;
        if (data && size > 4'(LG_BB))
            r = BEAT_W'((32'd1 << (size - 4'(LG_BB))) - 32'd1);
        return r;
    endfunction

    logic [SOURCES-1:0]      inflight_q, inflight_d;
    logic [SOURCES-1:0][1:0] exp_op_q, exp_op_d;
    logic [SOURCES-1:0][3:0] size_q, size_d;
    logic [BEAT_W-1:0]       a_beats_q, a_beats_d, d_beats_q, d_beats_d;
    logic [7:0]              count_q, count_d;
    logic [4:0]              err_q, err_d;
    logic                    pulse_q, pulse_d;

    logic a_fire, d_fire, a_known, d_known, alloc, d_check, d_last, release_ok;
    logic [1:0] a_exp_op;

    logic unused_inputs;
    assign unused_inputs = ^{a_address, d_denied};

`ifdef TL_TRACKER_WATCHDOG_EN
    logic [12:0] wd_q, wd_d;
`endif

    always_comb begin
        a_fire  = a_valid & a_ready;
        d_fire  = d_valid & d_ready;
        a_known = a_opcode < 3'd6;
        d_known = d_opcode < 3'd6;
        alloc   = a_fire && (a_beats_q == '0) && a_known;
        d_check = d_fire && (d_beats_q == '0) && d_known;
        d_last  = d_fire && ((d_beats_q == BEAT_W'(1)) ||
                  ((d_beats_q == '0) && d_known && (beats_m1(d_size, d_opcode == 3'd1) == '0)));
        // A same-cycle allocation on the same source overrides the release.
        release_ok = d_last && inflight_q[d_source] && !(alloc && (a_source == d_source));

        case (a_opcode)
            3'd0, 3'd1:       a_exp_op = 2'd0;
            3'd2, 3'd3, 3'd4: a_exp_op = 2'd1;
            3'd5:             a_exp_op = 2'd2;
            default:          a_exp_op = 2'd0;
        endcase

        a_beats_d = a_beats_q;
        if (a_fire) begin
            if (a_beats_q == '0) begin
                if (a_known) a_beats_d = beats_m1(a_size, a_opcode <= 3'd1);
            end else begin
                a_beats_d = a_beats_q - BEAT_W'(1);
            end
        end

        d_beats_d = d_beats_q;
        if (d_fire) begin
            if (d_beats_q == '0) begin
                if (d_known) d_beats_d = beats_m1(d_size, d_opcode == 3'd1);
            end else begin
                d_beats_d = d_beats_q - BEAT_W'(1);
            end
        end

        err_d = err_q;
        if (alloc && inflight_q[a_source]) err_d[0] = 1'b1;
        if (d_check) begin
            if (!inflight_q[d_source]) begin
                err_d[1] = 1'b1;
            end else begin
                if (d_opcode != {1'b0, exp_op_q[d_source]}) err_d[2] = 1'b1;
                if (d_size != size_q[d_source])             err_d[3] = 1'b1;
            end
        end

`ifdef TL_TRACKER_WATCHDOG_EN
        wd_d = wd_q;
        if (d_fire || (count_q == 8'd0))
            wd_d = '0;
        else if (wd_q != 13'(TIMEOUT))
            wd_d = wd_q + 13'd1;
        if (wd_d == 13'(TIMEOUT)) err_d[4] = 1'b1;
`else
        err_d[4] = 1'b0;
`endif

        inflight_d = inflight_q;
        exp_op_d   = exp_op_q;
        size_d     = size_q;
        if (release_ok) inflight_d[d_source] = 1'b0;
        if (alloc) begin
            inflight_d[a_source] = 1'b1;
            exp_op_d[a_source]   = a_exp_op;
            size_d[a_source]     = a_size;
        end

        count_d = count_q;
        if ((alloc && !inflight_q[a_source]) && !release_ok)
            count_d = count_q + 8'd1;
        else if (release_ok && !(alloc && !inflight_q[a_source]))
            count_d = count_q - 8'd1;

        pulse_d = |(err_d & ~err_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= '0;
            exp_op_q   <= '0;
            size_q     <= '0;
            a_beats_q  <= '0;
            d_beats_q  <= '0;
            count_q    <= '0;
            err_q      <= '0;
            pulse_q    <= 1'b0;
`ifdef TL_TRACKER_WATCHDOG_EN
            wd_q       <= '0;
`endif
        end else begin
            inflight_q <= inflight_d;
            exp_op_q   <= exp_op_d;
            size_q     <= size_d;
            a_beats_q  <= a_beats_d;
            d_beats_q  <= d_beats_d;
            count_q    <= count_d;
            err_q      <= err_d;
            pulse_q    <= pulse_d;
`ifdef TL_TRACKER_WATCHDOG_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign inflight_count = count_q;
    assign err_sticky     = err_q;
    assign err_pulse      = pulse_q;
endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Bench for tl_inflight_tracker: message-level reference model compared every cycle,
// directed scenarios pinned with literal expectations, randomized traffic rounds.
module tb_tl_inflight_tracker;
    localparam int TIMEOUT = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, a_ready = 1'b0;
    logic [2:0]  a_opcode = '0;
    logic [3:0]  a_size = '0;
    logic [6:0]  a_source = '0;
    logic [29:0] a_address = '0;
    logic        d_valid = 1'b0, d_ready = 1'b0;
    logic [2:0]  d_opcode = '0;
    logic [3:0]  d_size = '0;
    logic [6:0]  d_source = '0;
    logic        d_denied = 1'b0;
    logic [7:0]  inflight_count;
    logic [4:0]  err_sticky;
    logic        err_pulse;

    tl_inflight_tracker #(.SOURCES(128), .BEAT_BYTES(4), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_denied(d_denied),
        .inflight_count(inflight_count), .err_sticky(err_sticky), .err_pulse(err_pulse)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] size;
        logic [6:0] src;
        logic       first;
        logic       last;
    } beat_t;

    beat_t a_q[$];
    beat_t d_q[$];
    bit    stall_en = 1'b0;
    bit    rst_req = 1'b1;
    bit    model_valid = 1'b0;
    int    checks = 0;
    int    failures = 0;

    // Reference model: one record per source plus the sticky flags.
    bit   [127:0] m_out;
    int           m_exp[128];
    int           m_sz[128];
    int           m_count;
    logic [4:0]   m_err;
    bit           m_pulse;
    int           m_wd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int nbeats(input bit is_d, input int op, input int size);
        bit data;
        data = is_d ? (op == 1) : (op <= 1);
        if (data && size > 2) return 1 << (size - 2);
        return 1;
    endfunction

    function automatic int resp_op(input int op);
        if (op <= 1) return 0;
        if (op <= 4) return 1;
        return 2;
    endfunction

    task automatic push_msg(input bit is_d, input int op, input int size, input int src);
        int n;
        beat_t b;
        n = nbeats(is_d, op, size);
        for (int i = 0; i < n; i++) begin
            b.op = 3'(op); b.size = 4'(size); b.src = 7'(src);
            b.first = (i == 0); b.last = (i == n - 1);
            if (is_d) d_q.push_back(b); else a_q.push_back(b);
        end
    endtask

    task automatic model_update();
        logic [4:0] ne;
        bit a_fire, d_fire, a_alloc, d_first_ok, d_rel;
        int cnt;
        if (reset) begin
            m_out = '0; m_count = 0; m_err = '0; m_pulse = 1'b0; m_wd = 0;
            model_valid = 1'b1;
            return;
        end
        a_fire = a_valid && a_ready;
        d_fire = d_valid && d_ready;
        ne = m_err;
        a_alloc = a_fire && a_q[0].first && (a_opcode < 3'd6);
        d_first_ok = d_fire && d_q[0].first && (d_opcode < 3'd6);
        d_rel = d_fire && d_q[0].last && (d_opcode < 3'd6) && m_out[d_source];
        if (a_alloc && m_out[a_source]) ne[0] = 1'b1;
        if (d_first_ok) begin
            if (!m_out[d_source]) ne[1] = 1'b1;
            else begin
                if (int'(d_opcode) != m_exp[d_source]) ne[2] = 1'b1;
                if (int'(d_size) != m_sz[d_source]) ne[3] = 1'b1;
            end
        end
`ifdef TL_TRACKER_WATCHDOG_EN
        if (d_fire || m_count == 0) m_wd = 0;
        else if (m_wd < TIMEOUT) m_wd++;
        if (m_wd == TIMEOUT) ne[4] = 1'b1;
`endif
        if (d_rel) m_out[d_source] = 1'b0;
        if (a_alloc) begin
            m_out[a_source] = 1'b1;
            m_exp[a_source] = resp_op(int'(a_opcode));
            m_sz[a_source]  = int'(a_size);
        end
        if (a_fire) void'(a_q.pop_front());
        if (d_fire) void'(d_q.pop_front());
        cnt = 0;
        for (int i = 0; i < 128; i++) cnt += int'(m_out[i]);
        m_count = cnt;
        m_pulse = ((ne & ~m_err) != 5'd0);
        m_err = ne;
    endtask

    // One clock: compare at negedge, drive the next inputs, advance the model after posedge.
    task automatic step();
        @(negedge clock);
        if (model_valid) begin
            check("inflight_count", 32'(inflight_count), 32'(m_count));
            check("err_sticky", 32'(err_sticky), 32'(m_err));
            check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        end
        reset = rst_req;
        a_address = 30'($urandom);
        d_denied = 1'($urandom);
        if (!rst_req && a_q.size() != 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
            a_valid = 1'b1; a_opcode = a_q[0].op; a_size = a_q[0].size; a_source = a_q[0].src;
        end else begin
            a_valid = 1'b0; a_opcode = 3'($urandom); a_size = 4'($urandom); a_source = 7'($urandom);
        end
        if (!rst_req && d_q.size() != 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
            d_valid = 1'b1; d_opcode = d_q[0].op; d_size = d_q[0].size; d_source = d_q[0].src;
        end else begin
            d_valid = 1'b0; d_opcode = 3'($urandom); d_size = 4'($urandom); d_source = 7'($urandom);
        end
        a_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        d_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge clock);
        model_update();
        rst_req = 1'b0;
    endtask

    task automatic do_reset();
        a_q.delete(); d_q.delete();
        rst_req = 1'b1;
        step();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((a_q.size() != 0 || d_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (a_q.size() != 0 || d_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d A and %0d D beats left after %0d cycles",
                     a_q.size(), d_q.size(), budget);
        end
    endtask

    initial begin
        do_reset();
        #1;
        check("reset_count", 32'(inflight_count), 32'd0);
        check("reset_err", 32'(err_sticky), 32'd0);
        check("reset_pulse", 32'(err_pulse), 32'd0);

        // Get size 2 then AccessAckData.
        push_msg(0, 4, 2, 5); drain(20); #1;
        check("get5_count", 32'(inflight_count), 32'd1);
        push_msg(1, 1, 2, 5); drain(20); #1;
        check("get5_done_count", 32'(inflight_count), 32'd0);
        check("get5_err", 32'(err_sticky), 32'd0);

        // Four-beat PutFull answered by a single AccessAck.
        push_msg(0, 0, 4, 3); drain(20); #1;
        check("put3_count", 32'(inflight_count), 32'd1);
        push_msg(1, 0, 4, 3); drain(20); #1;
        check("put3_done_count", 32'(inflight_count), 32'd0);
        check("put3_err", 32'(err_sticky), 32'd0);

        // Source reuse.
        do_reset();
        push_msg(0, 4, 2, 9); push_msg(0, 4, 2, 9); drain(20); #1;
        check("reuse_err", 32'(err_sticky), 32'd1);
        check("reuse_pulse", 32'(err_pulse), 32'd1);
        check("reuse_count", 32'(inflight_count), 32'd1);
        step(); #1;
        check("reuse_pulse_drop", 32'(err_pulse), 32'd0);

        // Unknown source, then opcode mismatch.
        do_reset();
        push_msg(1, 0, 2, 12); drain(20); #1;
        check("unknown_err", 32'(err_sticky), 32'd2);
        push_msg(0, 4, 2, 12); drain(20);
        push_msg(1, 0, 2, 12); drain(20); #1;
        check("opmis_err", 32'(err_sticky), 32'b00110);

        // Same-cycle A first beat and D last beat on one source.
        do_reset();
        push_msg(0, 4, 2, 7); drain(20);
        push_msg(0, 4, 2, 7); push_msg(1, 1, 2, 7); drain(20); #1;
        check("same_cycle_err", 32'(err_sticky), 32'd1);
        check("same_cycle_count", 32'(inflight_count), 32'd1);

        // Size mismatch on a two-beat AccessAckData still releases.
        do_reset();
        push_msg(0, 4, 2, 4); drain(20);
        push_msg(1, 1, 3, 4); drain(20); #1;
        check("sizemis_err", 32'(err_sticky), 32'b01000);
        check("sizemis_count", 32'(inflight_count), 32'd0);

        // Intent/HintAck pairing, and opcodes 6/7 ignored.
        do_reset();
        push_msg(0, 5, 0, 6); push_msg(0, 6, 0, 2); drain(20);
        push_msg(1, 2, 0, 6); push_msg(1, 7, 0, 2); drain(20); #1;
        check("hint_err", 32'(err_sticky), 32'd0);
        check("hint_count", 32'(inflight_count), 32'd0);

        // A response to a request issued before reset is unknown.
        push_msg(0, 4, 2, 20); drain(20);
        do_reset();
        push_msg(1, 1, 2, 20); drain(20); #1;
        check("prereset_err", 32'(err_sticky), 32'd2);
        check("prereset_count", 32'(inflight_count), 32'd0);

`ifdef TL_TRACKER_WATCHDOG_EN
        do_reset();
        push_msg(0, 4, 2, 1); drain(20);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        #1;
        check("wd_before", 32'(err_sticky), 32'd0);
        step(); #1;
        check("wd_fire", 32'(err_sticky), 32'b10000);
        check("wd_pulse", 32'(err_pulse), 32'd1);
        do_reset(); #1;
        check("wd_reset_err", 32'(err_sticky), 32'd0);
        check("wd_reset_count", 32'(inflight_count), 32'd0);
`endif

        // Randomized rounds with stalls; responses mostly correct, some junk.
        stall_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int m = 0; m < 40; m++) begin
                int op, sz, src;
                op  = $urandom_range(0, 7);
                sz  = $urandom_range(0, 4);
                src = $urandom_range(0, 15);
                push_msg(0, op, sz, src);
                if (op < 6 && $urandom_range(0, 3) != 0)
                    push_msg(1, resp_op(op), sz, src);
                else if ($urandom_range(0, 3) == 0)
                    push_msg(1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
            end
            drain(5000);
            for (int i = 0; i < 3; i++) step();
        end
        stall_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
